// File: rtl/kws_pkg.sv
// rtl/kws_pkg.sv - shared constants, FSM encoding and clog2 helper for the keyword decision block
package kws_pkg;

  localparam int          KWS_PROB_W    = 16;
  localparam logic [15:0] KWS_THRESHOLD = 16'hC000;
  localparam int          KWS_HOLDOFF   = 8;

  localparam logic [0:0] ST_ACCUM  = 1'b0;
  localparam logic [0:0] ST_DECIDE = 1'b1;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/kws_smooth_hist.sv
// rtl/kws_smooth_hist.sv - per-class circular probability history with running window sums
module kws_smooth_hist
  import kws_pkg::*;
#(
  parameter int NUM_CLASSES = 2,
  parameter int PROB_WIDTH  = KWS_PROB_W,
  parameter int SMOOTH_LEN  = 4,
  localparam int CLASS_W    = (NUM_CLASSES > 2) ? clog2(NUM_CLASSES) : 1,
  localparam int LOG_SL     = clog2(SMOOTH_LEN),
  localparam int SUM_W      = PROB_WIDTH + LOG_SL
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [CLASS_W-1:0]                    cls,
  input  logic [PROB_WIDTH-1:0]                 wdata,
  input  logic                                  we,
  input  logic [LOG_SL-1:0]                     wp,
  output logic [NUM_CLASSES-1:0][SUM_W-1:0]     sums
);

  logic [PROB_WIDTH-1:0] hist [NUM_CLASSES][SMOOTH_LEN];

  // The slot being overwritten is the oldest frame, so swapping it out keeps the sum exact.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NUM_CLASSES; c++) begin
        for (int s = 0; s < SMOOTH_LEN; s++) begin
          hist[c][s] <= '0;
        end
      end
      sums <= '0;
    end else if (we) begin
      hist[cls][wp] <= wdata;
      sums[cls]     <= sums[cls] - SUM_W'(hist[cls][wp]) + SUM_W'(wdata);
    end
  end

endmodule

// File: rtl/kws_decision.sv
// rtl/kws_decision.sv - smoothed argmax keyword detector with threshold and frame hold-off
module kws_decision
  import kws_pkg::*;
#(
  parameter int                  NUM_CLASSES    = 2,
  parameter int                  PROB_WIDTH     = KWS_PROB_W,
  parameter int                  SMOOTH_LEN     = 4,
  parameter logic [PROB_WIDTH-1:0] THRESHOLD    = KWS_THRESHOLD,
  parameter int                  HOLDOFF_FRAMES = KWS_HOLDOFF,
  localparam int                 CLASS_W        = (NUM_CLASSES > 2) ? clog2(NUM_CLASSES) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [PROB_WIDTH-1:0] prob_in,
  input  logic                  prob_valid,
  input  logic                  prob_last,
  output logic                  prob_ready,
  output logic                  detect,
  output logic [CLASS_W-1:0]    detect_class,
  output logic [PROB_WIDTH-1:0] detect_conf,
  output logic                  frame_done,
  output logic                  framing_err
);

  localparam int LOG_SL = clog2(SMOOTH_LEN);
  localparam int SUM_W  = PROB_WIDTH + LOG_SL;
  localparam int FC_W   = clog2(SMOOTH_LEN + 1);
  localparam int HO_W   = (HOLDOFF_FRAMES > 0) ? clog2(HOLDOFF_FRAMES + 1) : 1;

  logic [0:0]                        state;
  logic [CLASS_W-1:0]                bc;
  logic [LOG_SL-1:0]                 wp;
  logic [FC_W-1:0]                   frame_cnt;
  logic [FC_W-1:0]                   frame_cnt_nxt;
  logic [HO_W-1:0]                   holdoff;
  logic [NUM_CLASSES-1:0][SUM_W-1:0] sums;
  logic                              beat;
  logic                              last_beat;
  logic [CLASS_W-1:0]                best_cls;
  logic [PROB_WIDTH-1:0]             best_avg;

  assign prob_ready = (state == ST_ACCUM);
  assign beat       = prob_valid && prob_ready;
  assign last_beat  = (bc == CLASS_W'(NUM_CLASSES - 1));

  kws_smooth_hist #(
    .NUM_CLASSES (NUM_CLASSES),
    .PROB_WIDTH  (PROB_WIDTH),
    .SMOOTH_LEN  (SMOOTH_LEN)
  ) u_hist (
    .clk   (clk),
    .rst_n (rst_n),
    .cls   (bc),
    .wdata (prob_in),
    .we    (beat),
    .wp    (wp),
    .sums  (sums)
  );

  // Dropping the low sum bits is the divide by the window length; strict > keeps ties on the lowest class.
  always_comb begin
    best_cls = CLASS_W'(1);
    best_avg = sums[1][SUM_W-1:LOG_SL];
    for (int c = 2; c < NUM_CLASSES; c++) begin
      if (sums[c][SUM_W-1:LOG_SL] > best_avg) begin
        best_avg = sums[c][SUM_W-1:LOG_SL];
        best_cls = CLASS_W'(c);
      end
    end
  end

  assign frame_cnt_nxt = (frame_cnt >= FC_W'(SMOOTH_LEN)) ? frame_cnt : frame_cnt + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_ACCUM;
      bc           <= '0;
      wp           <= '0;
      frame_cnt    <= '0;
      holdoff      <= '0;
      detect       <= 1'b0;
      detect_class <= '0;
      detect_conf  <= '0;
      frame_done   <= 1'b0;
      framing_err  <= 1'b0;
    end else begin
      detect     <= 1'b0;
      frame_done <= 1'b0;
      if (beat && (prob_last != last_beat)) begin
        framing_err <= 1'b1;
      end
      case (state)
        ST_ACCUM: begin
          if (beat) begin
            if (last_beat) begin
              bc    <= '0;
              state <= ST_DECIDE;
            end else begin
              bc <= bc + 1'b1;
            end
          end
        end
        default: begin
          state      <= ST_ACCUM;
          wp         <= wp + 1'b1;
          frame_cnt  <= frame_cnt_nxt;
          frame_done <= 1'b1;
          if (holdoff != '0) begin
            holdoff <= holdoff - 1'b1;
          end else if ((frame_cnt_nxt >= FC_W'(SMOOTH_LEN)) && (best_avg >= THRESHOLD)) begin
            detect       <= 1'b1;
            detect_class <= best_cls;
            detect_conf  <= best_avg;
            holdoff      <= HO_W'(HOLDOFF_FRAMES);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_kws_decision.sv
// tb/tb_kws_decision.sv - scoreboard bench for kws_decision against a frame-window reference model
module tb_kws_decision;

  localparam int          NC  = 3;
  localparam int          PW  = 16;
  localparam int          SL  = 4;
  localparam int          HO  = 8;
  localparam logic [15:0] THR = 16'hC000;
  localparam int          CW  = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [PW-1:0] prob_in;
  logic          prob_valid;
  logic          prob_last;
  logic          prob_ready;
  logic          detect;
  logic [CW-1:0] detect_class;
  logic [PW-1:0] detect_conf;
  logic          frame_done;
  logic          framing_err;

  always #5 clk = ~clk;

  kws_decision #(
    .NUM_CLASSES    (NC),
    .PROB_WIDTH     (PW),
    .SMOOTH_LEN     (SL),
    .THRESHOLD      (THR),
    .HOLDOFF_FRAMES (HO)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .prob_in      (prob_in),
    .prob_valid   (prob_valid),
    .prob_last    (prob_last),
    .prob_ready   (prob_ready),
    .detect       (detect),
    .detect_class (detect_class),
    .detect_conf  (detect_conf),
    .frame_done   (frame_done),
    .framing_err  (framing_err)
  );

  typedef logic [NC-1:0][15:0] frame_t;
  typedef struct {
    bit det;
    int cls;
    int conf;
    bit ferr;
    int cyc;
  } exp_t;

  exp_t   sb[$];
  frame_t hist_q[$];
  int     tests = 0;
  int     fails = 0;
  int     cyc = 0;
  int     nframes, last_det, m_cls, m_conf;
  bit     m_ferr;
  int     ready_low = 0;
  int     total_frames = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops one expectation per frame decision the DUT reports.
  always @(negedge clk) begin
    if (rst_n) begin
      exp_t e;
      if (!prob_ready) ready_low++;
      check("detect_without_frame_done", int'(detect && !frame_done), 0);
      if (frame_done) begin
        check("frame_done_expected", int'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check("frame_latency", cyc, e.cyc);
          check("detect", int'(detect), int'(e.det));
          check("detect_class", int'(detect_class), e.cls);
          check("detect_conf", int'(detect_conf), e.conf);
          check("framing_err", int'(framing_err), int'(e.ferr));
        end
      end
    end
  end

  function automatic frame_t mk(input int a, input int b, input int c);
    frame_t f;
    f[0] = 16'(a);
    f[1] = 16'(b);
    f[2] = 16'(c);
    return f;
  endfunction

  task automatic send_beat(input logic [15:0] d, input bit last, output int acc_cyc);
    bit r;
    int n;
    prob_in    = d;
    prob_last  = last;
    prob_valid = 1'b1;
    n = 0;
    r = 1'b0;
    while (!r) begin
      @(negedge clk);
      r = prob_ready;
      acc_cyc = cyc;
      @(posedge clk);
      #1;
      n++;
      if (!r && n > 100) begin
        $display("FAIL prob_ready_timeout: ready stuck low for %0d cycles", n);
        $fatal(1);
      end
    end
  endtask

  // Model: window average over the last SL frames (cleared history counts as zero).
  task automatic model_frame(input frame_t f, input int acc_cyc);
    exp_t e;
    int   best, bcls, s, a;
    bit   det;
    hist_q.push_back(f);
    if (hist_q.size() > SL) void'(hist_q.pop_front());
    nframes++;
    total_frames++;
    best = -1;
    bcls = 1;
    for (int c = 1; c < NC; c++) begin
      s = 0;
      foreach (hist_q[i]) s += int'(hist_q[i][c]);
      a = s / SL;
      if (a > best) begin
        best = a;
        bcls = c;
      end
    end
    det = (nframes >= SL) && ((nframes - last_det) > HO) && (best >= int'(THR));
    if (det) begin
      last_det = nframes;
      m_cls    = bcls;
      m_conf   = best;
    end
    e.det  = det;
    e.cls  = m_cls;
    e.conf = m_conf;
    e.ferr = m_ferr;
    e.cyc  = acc_cyc + 2;
    sb.push_back(e);
  endtask

  task automatic send_frame(input frame_t f, input bit cont, input int gap_max, input int bad_pos);
    int  k;
    bit  last;
    for (int c = 0; c < NC; c++) begin
      last = (c == NC - 1);
      if (c == bad_pos) last = !last;
      send_beat(f[c], last, k);
      if (last != (c == NC - 1)) m_ferr = 1'b1;
      if (!cont && gap_max > 0 && c < NC - 1) begin
        int g;
        g = $urandom_range(0, gap_max);
        if (g > 0) begin
          prob_valid = 1'b0;
          repeat (g) @(posedge clk);
          #1;
        end
      end
    end
    model_frame(f, k);
    if (!cont) begin
      prob_valid = 1'b0;
      if (gap_max > 0) begin
        repeat ($urandom_range(0, gap_max)) @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() > 0 && n < 20) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("scoreboard_drained", sb.size(), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n      = 1'b0;
    prob_valid = 1'b0;
    #1;
    check("rst_detect", int'(detect), 0);
    check("rst_detect_class", int'(detect_class), 0);
    check("rst_detect_conf", int'(detect_conf), 0);
    check("rst_frame_done", int'(frame_done), 0);
    check("rst_framing_err", int'(framing_err), 0);
    check("rst_prob_ready", int'(prob_ready), 1);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    hist_q.delete();
    sb.delete();
    nframes  = 0;
    last_det = -1000;
    m_cls    = 0;
    m_conf   = 0;
    m_ferr   = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int k;
    int hot;
    frame_t f;
    rst_n      = 1'b0;
    prob_valid = 1'b0;
    prob_in    = '0;
    prob_last  = 1'b0;
    do_reset();

    // Warm-up then hold-off: detects expected on frames 4 and 13.
    for (int i = 0; i < 14; i++) send_frame(mk(16'h2000, 16'hE000, 16'h0000), 1'b0, 0, -1);
    drain();

    // Threshold boundary cases.
    do_reset();
    for (int i = 0; i < 5; i++) send_frame(mk(16'h3000, 16'hC000, 16'h0000), 1'b0, 1, -1);
    drain();
    do_reset();
    for (int i = 0; i < 6; i++) send_frame(mk(16'h3000, 16'hBFFF, 16'h0000), 1'b0, 1, -1);
    drain();
    do_reset();
    for (int i = 0; i < 3; i++) send_frame(mk(16'h3000, 16'hC000, 16'h0000), 1'b0, 0, -1);
    send_frame(mk(16'h3000, 16'hBFFC, 16'h0000), 1'b0, 0, -1);
    drain();

    // Tie goes to the lowest class; background alone never detects.
    do_reset();
    for (int i = 0; i < 5; i++) send_frame(mk(16'hF000, 16'hD000, 16'hD000), 1'b0, 0, -1);
    drain();
    do_reset();
    for (int i = 0; i < 6; i++) send_frame(mk(16'hFFFF, 16'h1000, 16'h1000), 1'b0, 0, -1);
    drain();

    // Framing errors: early prob_last, then a missing one; flag must stick.
    do_reset();
    send_frame(mk(16'h1000, 16'h2000, 16'h3000), 1'b0, 0, 0);
    check("framing_err_set", int'(framing_err), 1);
    send_frame(mk(16'h1000, 16'hF000, 16'h3000), 1'b0, 0, -1);
    send_frame(mk(16'h1000, 16'hF000, 16'h3000), 1'b0, 0, NC - 1);
    send_frame(mk(16'h1000, 16'hF000, 16'h3000), 1'b0, 0, -1);
    drain();
    check("framing_err_sticky", int'(framing_err), 1);

    // Reset mid-frame discards the partial frame and restarts warm-up.
    for (int i = 0; i < 3; i++) send_frame(mk(16'h0000, 16'hF000, 16'h0000), 1'b0, 0, -1);
    drain();
    send_beat(16'h0000, 1'b0, k);
    prob_valid = 1'b0;
    do_reset();
    for (int i = 0; i < 5; i++) send_frame(mk(16'h0000, 16'hF000, 16'h0000), 1'b0, 0, -1);
    drain();

    // Back-pressure: valid held high across frames.
    do_reset();
    for (int i = 0; i < 12; i++) begin
      f = mk($urandom_range(0, 16'hFFFF), $urandom_range(16'hA000, 16'hFFFF), $urandom_range(0, 16'hFFFF));
      send_frame(f, 1'b1, 0, -1);
    end
    prob_valid = 1'b0;
    drain();

    // Randomised traffic with a drifting dominant class, gaps and bursts.
    hot = 1;
    for (int i = 0; i < 80; i++) begin
      if (i % 6 == 0) hot = $urandom_range(1, NC - 1);
      for (int c = 0; c < NC; c++) begin
        f[c] = (c == hot) ? 16'($urandom_range(16'hB800, 16'hFFFF)) : 16'($urandom_range(0, 16'h4000));
      end
      send_frame(f, 1'($urandom_range(0, 1)), 2, -1);
    end
    prob_valid = 1'b0;
    drain();

    check("ready_low_one_cycle_per_frame", ready_low, total_frames);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
